tinyml_hw_accel_pack_ctrl: RTL and testbench

Frame-level sequencer for the RGB/grayscale pixel packer in the TinyML hardware accelerator. It accepts a pixel stream with a valid/ready handshake and forwards exactly one configured frame of pixels to the packer. It zero-pads each frame to a multiple of 4 pixels so packing stays aligned, and applies backpressure from the downstream write FIFO. It counts the packed 32-bit words returned by the packer and signals frame completion, so the DMA/CPU side can tell when a frame is fully written.

---
 rtl/tinyml_hw_accel_pack_ctrl.sv | 135 +++++++++++++
 tb/tb_tinyml_hw_accel_pack_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_hw_accel_pack_ctrl.sv
// Frame sequencer for the pixel packer: forwards one configured frame of pixels,
// zero-pads it to a multiple of 4, honours downstream backpressure and counts
// returned packed words to signal frame completion.
module tinyml_hw_accel_pack_ctrl #(
  parameter int unsigned PIX_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [PIX_W-1:0] cfg_pixel_count,
  input  logic [1:0]       cfg_mode,
  input  logic             s_pixel_valid,
  output logic             s_pixel_ready,
  input  logic [23:0]      s_rgb,
  input  logic [7:0]       s_gray,
  input  logic             fifo_afull,
  output logic             pk_rst,
  output logic             pk_valid,
  output logic [23:0]      pk_rgb,
  output logic [7:0]       pk_gray,
  input  logic             pk_word_valid,
  output logic             busy,
  output logic             done,
  output logic [PIX_W-1:0] word_count
);

  typedef enum logic [2:0] {StIdle, StRun, StPad, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [PIX_W-1:0] rem_q;       // data pixels still to accept
  logic [1:0]       pad_q;       // zero pixels still to issue
  logic [PIX_W-1:0] exp_q;       // packed words expected for this frame
  logic [PIX_W-1:0] wc_q;
  logic             pk_rst_q, pk_valid_q;
  logic [23:0]      pk_rgb_q;
  logic [7:0]       pk_gray_q;

  logic             start_ok, abort_ok, hs, pad_issue, gray_sel;
  logic [1:0]       n_pad;
  logic [PIX_W-1:0] total, words4, exp_d;

  // Start/abort qualification and expected-word computation at configuration time.
  always_comb begin
    abort_ok = cfg_abort && (state_q != StIdle);
    // Abort in the same cycle drops the start.
    start_ok = cfg_start && !cfg_abort && (state_q == StIdle);
    gray_sel = (cfg_mode == 2'd2) || (cfg_mode == 2'd3);
    n_pad    = 2'd0 - cfg_pixel_count[1:0];
    total    = cfg_pixel_count + PIX_W'(n_pad);
    words4   = total >> 2;
    exp_d    = gray_sel ? words4 : words4 + (words4 << 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state, upstream ready and pixel/pad issue strobes.
  always_comb begin
    state_d       = state_q;
    s_pixel_ready = 1'b0;
    pad_issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = (cfg_pixel_count == '0) ? StDone : StRun;
      end
      StRun: begin
        // Abort gates ready so no pixel is consumed and then discarded.
        s_pixel_ready = !fifo_afull && !cfg_abort;
        if (s_pixel_valid && s_pixel_ready && rem_q == PIX_W'(1)) begin
          state_d = (pad_q != 2'd0) ? StPad : StDrain;
        end
      end
      StPad: begin
        pad_issue = !fifo_afull && !cfg_abort;
        if (pad_issue && pad_q == 2'd1) state_d = StDrain;
      end
      StDrain: begin
        if (wc_q == exp_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort_ok) state_d = StIdle;
    hs = s_pixel_valid && s_pixel_ready;
  end

  // Frame counters, word counter and registered packer outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      pad_q      <= 2'd0;
      exp_q      <= '0;
      wc_q       <= '0;
      pk_rst_q   <= 1'b1;
      pk_valid_q <= 1'b0;
      pk_rgb_q   <= '0;
      pk_gray_q  <= '0;
    end else begin
      pk_rst_q   <= start_ok || abort_ok;
      pk_valid_q <= hs || pad_issue;
      if (start_ok) begin
        rem_q <= cfg_pixel_count;
        pad_q <= n_pad;
        exp_q <= exp_d;
        wc_q  <= '0;
      end else begin
        if (hs)        rem_q <= rem_q - PIX_W'(1);
        if (pad_issue) pad_q <= pad_q - 2'd1;
        if (pk_word_valid && (state_q != StIdle) && (wc_q != '1)) wc_q <= wc_q + PIX_W'(1);
      end
      if (hs) begin
        pk_rgb_q  <= s_rgb;
        pk_gray_q <= s_gray;
      end else if (pad_issue) begin
        pk_rgb_q  <= '0;
        pk_gray_q <= '0;
      end
    end
  end

  assign pk_rst     = pk_rst_q;
  assign pk_valid   = pk_valid_q;
  assign pk_rgb     = pk_rgb_q;
  assign pk_gray    = pk_gray_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign word_count = wc_q;

endmodule

// File: tb/tb_tinyml_hw_accel_pack_ctrl.sv
// Directed bench for the pack sequencer with a small behavioural packer model
// that returns words one cycle after the pixel that completes them.
module tb_tinyml_hw_accel_pack_ctrl;

  localparam int unsigned PW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [PW-1:0] cfg_pixel_count = '0;
  logic [1:0]    cfg_mode = 2'd0;
  logic          s_pixel_valid = 1'b0, s_pixel_ready;
  logic [23:0]   s_rgb = '0;
  logic [7:0]    s_gray = '0;
  logic          fifo_afull = 1'b0;
  logic          pk_rst, pk_valid, pk_word_valid = 1'b0, busy, done;
  logic [23:0]   pk_rgb;
  logic [7:0]    pk_gray;
  logic [PW-1:0] word_count;

  always #5 clk = ~clk;

  tinyml_hw_accel_pack_ctrl #(.PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_pixel_count(cfg_pixel_count), .cfg_mode(cfg_mode),
    .s_pixel_valid(s_pixel_valid), .s_pixel_ready(s_pixel_ready),
    .s_rgb(s_rgb), .s_gray(s_gray), .fifo_afull(fifo_afull),
    .pk_rst(pk_rst), .pk_valid(pk_valid), .pk_rgb(pk_rgb), .pk_gray(pk_gray),
    .pk_word_valid(pk_word_valid), .busy(busy), .done(done), .word_count(word_count)
  );

  int n_vec = 0, n_miss = 0;
  int pkv_cnt, pkrst_cnt, done_cnt, busy_cnt, overlap_cnt, stall_bad, hs_cnt, model_pix;
  logic model_gray = 1'b0, wv_next = 1'b0, hs, afull_edge;
  logic [23:0] got_rgb[$];
  logic [7:0]  got_gray[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int i);
    logic [23:0] v;
    v = 24'h010203 * 24'(i + 1);
    return v;
  endfunction

  function automatic logic [7:0] pix_gray(input int i);
    logic [7:0] v;
    v = 8'h10 + 8'(i);
    return v;
  endfunction

  task automatic clear_obs();
    pkv_cnt = 0; pkrst_cnt = 0; done_cnt = 0; busy_cnt = 0; overlap_cnt = 0;
    stall_bad = 0; hs_cnt = 0;
    got_rgb.delete(); got_gray.delete();
  endtask

  // One clock: sample the handshake mid-cycle, then observe registered outputs
  // and run the packer model.
  task automatic tick();
    @(negedge clk);
    hs = s_pixel_valid && s_pixel_ready;
    afull_edge = fifo_afull;
    if (fifo_afull && s_pixel_ready) stall_bad++;
    @(posedge clk);
    #1;
    if (hs) hs_cnt++;
    pk_word_valid = wv_next;
    wv_next = 1'b0;
    if (pk_rst) begin
      model_pix = 0;
      pkrst_cnt++;
    end
    if (pk_valid) begin
      pkv_cnt++;
      if (afull_edge) stall_bad++;
      got_rgb.push_back(pk_rgb);
      got_gray.push_back(pk_gray);
      model_pix++;
      wv_next = model_gray ? (model_pix % 4 == 0) : (model_pix % 4 != 1);
    end
    if (pk_valid && pk_rst) overlap_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  // Runs one frame; returns the tick index at which done was first seen (-1 if none).
  task automatic run_frame(input int n, input int src_n, input logic [1:0] mode,
                           input int abort_after, input int restart_c, input bit afull_pat,
                           output int done_c);
    bit fin;
    clear_obs();
    model_gray = mode[1];
    done_c = -1;
    fin = 1'b0;
    cfg_start = 1'b1; cfg_pixel_count = PW'(n); cfg_mode = mode;
    tick();
    cfg_start = 1'b0;
    if (done_cnt > 0) begin
      done_c = 0;
      fin = 1'b1;
    end
    for (int c = 1; c < 200 && !fin; c++) begin
      fifo_afull    = afull_pat && ((c >= 3 && c <= 5) || (c >= 10 && c <= 12));
      s_pixel_valid = (hs_cnt < src_n);
      s_rgb         = pix_rgb(hs_cnt);
      s_gray        = pix_gray(hs_cnt);
      if (c == restart_c) begin
        cfg_start = 1'b1; cfg_pixel_count = PW'(12);
      end
      if (abort_after > 0 && hs_cnt == abort_after) cfg_abort = 1'b1;
      tick();
      cfg_start = 1'b0;
      if (cfg_abort) begin
        cfg_abort = 1'b0;
        fin = 1'b1;
      end else if (done_cnt > 0) begin
        done_c = c;
        fin = 1'b1;
      end
    end
    s_pixel_valid = 1'b0;
    fifo_afull = 1'b0;
    if (!fin) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_data(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < got_rgb.size(); i++) begin
      if (i < n) begin
        if (got_rgb[i] !== pix_rgb(i) || got_gray[i] !== pix_gray(i)) bad++;
      end else if (got_rgb[i] !== 24'h0 || got_gray[i] !== 8'h0) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic after_done(input string tag);
    tick();
    check({tag, "_busy_fall"}, {done, busy}, 2'b00);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_pkrst_once"}, pkrst_cnt, 1);
    check({tag, "_no_overlap"}, overlap_cnt, 0);
  endtask

  initial begin
    int dc;
    clear_obs();
    model_pix = 0;
    // Reset values
    s_pixel_valid = 1'b1;
    repeat (2) tick();
    check("rst_ready", s_pixel_ready, 0);
    check("rst_outs", {pk_rst, pk_valid, busy, done}, 4'b1000);
    check("rst_data", {pk_rgb, pk_gray}, 0);
    check("rst_wc", word_count, 0);
    rst = 1'b0; s_pixel_valid = 1'b0;
    repeat (2) tick();
    check("idle_pkrst_low", pk_rst, 0);

    // RGB mode 0, N=8, continuous
    run_frame(8, 8, 2'd0, 0, 0, 1'b0, dc);
    check("m0_done_cycle", dc, 11);
    check("m0_pkv", pkv_cnt, 8);
    check_data("m0_data", 8);
    check("m0_wc", word_count, 6);
    after_done("m0");

    // Gray, N=6 -> 2 pad pixels, E=2
    run_frame(6, 6, 2'd2, 0, 0, 1'b0, dc);
    check("gr_pkv", pkv_cnt, 8);
    check_data("gr_data_pad", 6);
    check("gr_wc", word_count, 2);
    after_done("gr");

    // RGB mode 1, N=5 with afull mid-frame and during pad
    run_frame(5, 5, 2'd1, 0, 0, 1'b1, dc);
    check("af_stall", stall_bad, 0);
    check("af_pkv", pkv_cnt, 8);
    check_data("af_data", 5);
    check("af_wc", word_count, 6);
    after_done("af");

    // N=0: straight to DONE
    run_frame(0, 0, 2'd0, 0, 0, 1'b0, dc);
    check("z_done_cycle", dc, 0);
    check("z_busy_cnt", busy_cnt, 1);
    check("z_pkv", pkv_cnt, 0);
    check("z_wc", word_count, 0);
    after_done("z");

    // Abort after 3 of 16 pixels
    run_frame(16, 16, 2'd0, 3, 0, 1'b0, dc);
    check("ab_idle", {busy, done, pk_rst}, 3'b001);
    check("ab_hs", hs_cnt, 3);
    check("ab_wc_held", word_count, 1);
    repeat (3) tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_wc_idle", word_count, 1);
    run_frame(4, 4, 2'd0, 0, 0, 1'b0, dc);
    check("ab_next_wc", word_count, 3);
    check_data("ab_next_data", 4);
    after_done("ab_next");

    // cfg_start during RUN ignored (N stays 4 though upstream offers 12)
    run_frame(4, 12, 2'd0, 0, 2, 1'b0, dc);
    check("rs_pkv", pkv_cnt, 4);
    check("rs_wc", word_count, 3);
    after_done("rs");

    // Reset mid-PAD
    clear_obs();
    model_gray = 1'b1;
    cfg_start = 1'b1; cfg_pixel_count = PW'(5); cfg_mode = 2'd2;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_pixel_valid = (hs_cnt < 5);
      s_rgb = pix_rgb(hs_cnt);
      s_gray = pix_gray(hs_cnt);
      tick();
    end
    check("pr_in_pad", {busy, pk_valid}, 2'b11);
    check("pr_pad_zero", {pk_rgb, pk_gray}, 0);
    check("pr_wc_pre", word_count, 1);
    s_pixel_valid = 1'b1;
    rst = 1'b1;
    tick();
    check("pr_outs", {pk_rst, pk_valid, busy, done, s_pixel_ready}, 5'b10000);
    check("pr_data", {pk_rgb, pk_gray}, 0);
    check("pr_wc", word_count, 0);
    rst = 1'b0; s_pixel_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
